// File: rtl/mux_stream_nto1.sv
// Registered N-to-1 stream multiplexer with valid/ready handshaking.
// Grants come from an external select (fixed mode) or a round-robin scan.
module mux_stream_nto1 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_en;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  scan_idx;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  assign load_en = !out_valid_q || out_ready;

  // Round-robin scan starts just after ptr and ends at ptr itself; the
  // SELW-bit add wraps modulo N because N is a power of two.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (!mode) begin
      if (in_valid[sel]) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        scan_idx = ptr_q + SELW'(k);
        if (!grant_vld && in_valid[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  assign xfer = load_en && grant_vld && !rst;

  always_comb begin
    in_ready = '0;
    in_ready[grant_idx] = xfer;
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (SELW'(k) == grant_idx) begin
        grant_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
      out_valid_d = 1'b1;
      if (mode) begin
        ptr_d = grant_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '1;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_stream_nto1.sv
// Directed vector bench for mux_stream_nto1 (WIDTH=8, N=4).
module tb_mux_stream_nto1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [1:0]  sel = '0;
  logic        mode = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_chan;

  int total = 0;
  int bad   = 0;

  mux_stream_nto1 #(.WIDTH(8), .N(4), .SELW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic        ordy;
    logic [31:0] data;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_oc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic m, logic [1:0] s, logic [3:0] v,
                              logic o, logic [31:0] d, logic [3:0] er,
                              logic eov, logic [7:0] eod, logic [1:0] eoc);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = s; t.vld = v; t.ordy = o; t.data = d;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_oc = eoc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam logic [31:0] DA = 32'hA3A2A1A0;
  localparam logic [31:0] DB = 32'hA3A25CA0;
  localparam logic [31:0] DC = 32'h33225C11;
  localparam logic [31:0] DD = 32'h77A2A1A0;

  initial begin
    int          cnt [4];
    logic [1:0]  e;

    // rst mode sel vld ordy data | rdy ov od oc
    vq.push_back(mk(1, 0, 0, 4'h0, 0, DA, 4'b0000, 0, 8'h00, 0)); // 0 reset
    vq.push_back(mk(1, 1, 0, 4'hF, 1, DA, 4'b0000, 0, 8'h00, 0)); // 1 reset blocks transfer
    vq.push_back(mk(0, 1, 0, 4'hF, 1, DA, 4'b0001, 1, 8'hA0, 0)); // 2 rr from ch0
    vq.push_back(mk(0, 1, 0, 4'hF, 1, DA, 4'b0010, 1, 8'hA1, 1));
    vq.push_back(mk(0, 1, 0, 4'hF, 1, DA, 4'b0100, 1, 8'hA2, 2));
    vq.push_back(mk(0, 1, 0, 4'hF, 1, DA, 4'b1000, 1, 8'hA3, 3));
    vq.push_back(mk(0, 1, 0, 4'hF, 1, DA, 4'b0001, 1, 8'hA0, 0)); // 6 wrap
    vq.push_back(mk(0, 0, 2, 4'hF, 1, DA, 4'b0100, 1, 8'hA2, 2)); // 7 fixed sel2
    vq.push_back(mk(0, 0, 2, 4'hF, 1, DA, 4'b0100, 1, 8'hA2, 2));
    vq.push_back(mk(0, 0, 2, 4'hB, 1, DA, 4'b0000, 0, 8'hA2, 2)); // 9 drain
    vq.push_back(mk(0, 0, 2, 4'hB, 1, DA, 4'b0000, 0, 8'hA2, 2));
    vq.push_back(mk(0, 0, 1, 4'h2, 0, DB, 4'b0010, 1, 8'h5C, 1)); // 11 load into empty stage
    vq.push_back(mk(0, 0, 1, 4'hF, 0, DC, 4'b0000, 1, 8'h5C, 1)); // 12 hold x3
    vq.push_back(mk(0, 0, 1, 4'hF, 0, DC, 4'b0000, 1, 8'h5C, 1));
    vq.push_back(mk(0, 0, 1, 4'hF, 0, DC, 4'b0000, 1, 8'h5C, 1));
    vq.push_back(mk(0, 0, 3, 4'hF, 1, DC, 4'b1000, 1, 8'h33, 3)); // 15 release + refill
    vq.push_back(mk(0, 1, 0, 4'hF, 1, DA, 4'b0010, 1, 8'hA1, 1)); // 16 ptr was 0
    vq.push_back(mk(0, 1, 0, 4'hF, 1, DA, 4'b0100, 1, 8'hA2, 2)); // 17 ptr=2
    vq.push_back(mk(0, 1, 0, 4'hA, 1, DA, 4'b1000, 1, 8'hA3, 3)); // 18 skip to ch3
    vq.push_back(mk(0, 1, 0, 4'hA, 1, DA, 4'b0010, 1, 8'hA1, 1)); // 19 wrap to ch1
    vq.push_back(mk(0, 1, 0, 4'h2, 1, DA, 4'b0010, 1, 8'hA1, 1)); // 20 only ptr valid
    vq.push_back(mk(0, 1, 0, 4'h8, 1, DD, 4'b1000, 1, 8'h77, 3)); // 21 load 0x77
    vq.push_back(mk(0, 0, 0, 4'hF, 0, DD, 4'b0000, 1, 8'h77, 3)); // 22 mode switch while held
    vq.push_back(mk(0, 0, 0, 4'hF, 1, DD, 4'b0001, 1, 8'hA0, 0)); // 23 ch0 only
    vq.push_back(mk(0, 0, 0, 4'hF, 1, DD, 4'b0001, 1, 8'hA0, 0));
    vq.push_back(mk(1, 1, 0, 4'hF, 1, DA, 4'b0000, 0, 8'h00, 0)); // 25 reset mid-stream
    vq.push_back(mk(0, 1, 0, 4'hF, 1, DA, 4'b0001, 1, 8'hA0, 0)); // 26 ch0 first
    vq.push_back(mk(0, 1, 0, 4'h0, 1, DA, 4'b0000, 0, 8'hA0, 0)); // 27 drain, keep data
    vq.push_back(mk(0, 1, 0, 4'h0, 0, DA, 4'b0000, 0, 8'hA0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst       = vq[i].rst;
      mode      = vq[i].mode;
      sel       = vq[i].sel;
      in_valid  = vq[i].vld;
      out_ready = vq[i].ordy;
      in_data   = vq[i].data;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vq[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vq[i].exp_ov));
      check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vq[i].exp_od));
      check($sformatf("v%0d out_chan", i), 32'(out_chan), 32'(vq[i].exp_oc));
    end

    // Fairness: last rr grant was ch0, so grants run 1,2,3,0,... one per cycle.
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        rst = 1'b0; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_data = DA;
        e = 2'(w * 4 + j + 1);
        #1;
        check($sformatf("fair w%0d j%0d in_ready", w, j), 32'(in_ready), 32'(4'b0001 << e));
        @(posedge clk);
        #1;
        check($sformatf("fair w%0d j%0d out_chan", w, j), 32'(out_chan), 32'(e));
        check($sformatf("fair w%0d j%0d out_data", w, j), 32'(out_data), 32'(8'hA0 + 8'(e)));
        cnt[out_chan]++;
      end
      for (int c = 0; c < 4; c++)
        check($sformatf("fair w%0d ch%0d count", w, c), 32'(cnt[c]), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_stream_nto1.md
# mux_stream_nto1

Parametrised, registered N-to-1 stream multiplexer; the next generation of our 4-to-1 select mux. It generalises data width and channel count. It adds valid/ready handshaking on every channel and a registered output stage. A mode input chooses between fixed (externally selected) and round-robin arbitration. It sits between multiple producers and a single shared consumer, for example several sources feeding one result bus.

## Interface
- `WIDTH`, 8: data bits per channel; 1..64.
- `N`, 4: number of input channels; power of two, 2..16.
- `SELW`, 2: select/channel-index width; must equal log2(N).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready; combinational; at most one bit high per cycle.
- `sel`  in  SELW  channel index used in fixed mode.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `out_data`  out  WIDTH  registered output word.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_chan`  out  SELW  index of the channel that supplied `out_data`.

## Operation
- There is one output register stage (`out_data`, `out_chan`, `out_valid`).
- `load_en` = !out_valid | out_ready. The stage can take a new word when it is empty or being drained in the same cycle.
- Grant selection is combinational from `mode`, `sel`, `in_valid` and `ptr`:
  - Fixed mode: grant is channel `sel` if `in_valid[sel]`. Otherwise there is no grant. Other channels are never granted.
  - Round-robin mode: scan channels ptr+1, ptr+2, … wrapping modulo N, ending at ptr itself. Grant the first channel with valid set.
- `in_ready[i]` = load_en & (grant exists) & (i == grant). All other ready bits are 0.
- A transfer on channel g happens when `in_valid[g]` & `in_ready[g]`. On that edge:
  - `out_data` <= channel g data.
  - `out_chan` <= g.
  - `out_valid` <= 1.
- In round-robin mode, `ptr` <= g on each transfer. In fixed mode `ptr` is left unchanged.
- Drain without refill (out_valid & out_ready & no transfer): `out_valid` <= 0. `out_data` and `out_chan` keep their last values.
- Hold (out_valid & !out_ready): no channel is readied, and all output registers remain stable.
- A change of `mode` or `sel` affects only the next grant. It never alters a word already held.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_chan` = 0.
  - `ptr` = N-1, so channel 0 has first priority after reset.
  - `in_ready` = 0 during reset.
- Reset mid-operation discards any held word. Upstream transfers in the reset cycle do not occur.

## Timing
- Latency: a word accepted on edge k appears with `out_valid`=1 after edge k.
- Throughput: one word per cycle when `out_ready` is held high and a grantable channel is valid.
- The ready path is combinational from `out_ready` to `in_ready`. There is no combinational path from `in_data` to `out_data`.
- Round-robin fairness: with all N channels continuously valid and `out_ready`=1, each channel is granted exactly once in every N consecutive cycles.
- Boundary at ptr = N-1: the scan wraps to channel 0 first.
- Boundary where only channel ptr is valid: it is re-granted (scan ends at ptr).
- Producers must hold `in_data` stable while `in_valid`=1 and `in_ready`=0. The block does not check this.

## Test plan
- Reset, then mode=1, WIDTH=8, N=4, all valid, data 0xA0..0xA3, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, with out_data matching; first out_valid one cycle after first accept.
- Mode=0, sel=2, all channels valid -> only in_ready[2] ever high; out_data = ch2 data every cycle. Then in_valid[2]=0 -> out_valid falls after one cycle and in_ready stays all-zero.
- Backpressure: out_ready=0 for 3 cycles with a word held (0x5C, chan 1) -> out_data/out_chan/out_valid unchanged and in_ready=0 throughout. Release -> 0x5C is consumed and the next word loads on the same edge.
- Round-robin skip/wrap: ptr=2 (after a ch2 grant), only ch1 and ch3 valid -> ch3 granted, then ch1.
- Mode switch: while 0x77 (chan 3) is held with out_ready=0, set mode=0, sel=0 -> 0x77 is delivered intact, and subsequent grants come only from ch0.
- Reset mid-stream: assert rst with out_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=0. After release with all valid in mode 1 -> channel 0 is granted first.
